// File: rtl/pong_timing_pkg.sv
// Shared timing constants and game-state encoding for the pong tick controller.
package pong_timing_pkg;

  localparam int unsigned CNT_W = 28;

  localparam logic [CNT_W-1:0] BASE_DIV_DEF   = 28'd1000000;
  localparam logic [CNT_W-1:0] DIV_STEP_DEF   = 28'd100000;
  localparam logic [CNT_W-1:0] PADDLE_DIV_DEF = 28'd500000;
  localparam logic [2:0]       MAX_LEVEL_DEF  = 3'd7;
  localparam logic [3:0]       SERVE_TICKS_DEF    = 4'd8;
  localparam logic [3:0]       HITS_PER_LEVEL_DEF = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

endpackage

// File: rtl/pong_tick_div.sv
// Programmable divide counter: counts while enabled, wraps at period-1.
// The >= compare lets a shrinking period take effect mid-count safely.
module pong_tick_div #(
  parameter int unsigned CNT_W = pong_timing_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt;

  assign wrap = (cnt >= (period - CNT_W'(1)));

  // Counter register: synchronous clear wins, otherwise advance/wrap when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : (cnt + CNT_W'(1));
    end
  end

endmodule

// File: rtl/pong_tick_ctrl.sv
// Pong game timing controller: game FSM, serve delay, hit-driven speed levels,
// and single-cycle ball/paddle update enables in the clock_in domain.
module pong_tick_ctrl #(
  parameter int unsigned      CNT_W          = pong_timing_pkg::CNT_W,
  parameter logic [CNT_W-1:0] BASE_DIV       = pong_timing_pkg::BASE_DIV_DEF,
  parameter logic [CNT_W-1:0] DIV_STEP       = pong_timing_pkg::DIV_STEP_DEF,
  parameter logic [2:0]       MAX_LEVEL      = pong_timing_pkg::MAX_LEVEL_DEF,
  parameter logic [CNT_W-1:0] PADDLE_DIV     = pong_timing_pkg::PADDLE_DIV_DEF,
  parameter logic [3:0]       SERVE_TICKS    = pong_timing_pkg::SERVE_TICKS_DEF,
  parameter logic [3:0]       HITS_PER_LEVEL = pong_timing_pkg::HITS_PER_LEVEL_DEF
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       pause_toggle,
  input  logic       hit,
  input  logic       miss,
  output logic       ball_tick,
  output logic       paddle_tick,
  output logic [1:0] state,
  output logic [2:0] level,
  output logic       running
);

  import pong_timing_pkg::state_t, pong_timing_pkg::ST_IDLE, pong_timing_pkg::ST_SERVE,
         pong_timing_pkg::ST_RUN, pong_timing_pkg::ST_PAUSE;

  state_t           state_q, state_d;
  state_t           saved_q, saved_d;
  logic [3:0]       serve_q, serve_d;
  logic [3:0]       hits_q, hits_d;
  logic [2:0]       level_q, level_d;
  logic [CNT_W-1:0] ball_div;
  logic             cnt_en, cnt_clr;
  logic             ball_wrap, paddle_wrap;

  // Ball period shrinks by one step per speed level.
  always_comb begin
    ball_div = BASE_DIV - (CNT_W'(level_q) * DIV_STEP);
  end

  pong_tick_div #(.CNT_W(CNT_W)) u_ball_div (
    .clk    (clock_in),
    .rst    (reset),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .period (ball_div),
    .wrap   (ball_wrap)
  );

  pong_tick_div #(.CNT_W(CNT_W)) u_paddle_div (
    .clk    (clock_in),
    .rst    (reset),
    .en     (cnt_en),
    .clr    (cnt_clr),
    .period (PADDLE_DIV),
    .wrap   (paddle_wrap)
  );

  // State, saved-state, serve, hit and level registers.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      saved_q <= ST_SERVE;
      serve_q <= '0;
      hits_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      serve_q <= serve_d;
      hits_q  <= hits_d;
      level_q <= level_d;
    end
  end

  // Tick registers: a wrap taken this cycle becomes a one-cycle enable next cycle.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      ball_tick   <= 1'b0;
      paddle_tick <= 1'b0;
    end else begin
      ball_tick   <= cnt_en && ball_wrap && (state_q == ST_RUN);
      paddle_tick <= cnt_en && paddle_wrap;
    end
  end

  // Next-state logic, prioritised: stop, start, miss, pause entry, pause exit.
  // Counters also hold on the cycle a pause is taken, so a resume continues
  // from exactly the count present when pause_toggle arrived.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    serve_d = serve_q;
    hits_d  = hits_q;
    level_d = level_q;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      cnt_clr = 1'b1;
      serve_d = '0;
      hits_d  = '0;
      level_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_SERVE;
            cnt_clr = 1'b1;
            serve_d = '0;
          end
        end
        ST_SERVE: begin
          if (pause_toggle) begin
            state_d = ST_PAUSE;
            saved_d = ST_SERVE;
          end else begin
            cnt_en = 1'b1;
            if (ball_wrap) begin
              if (serve_q == (SERVE_TICKS - 4'd1)) begin
                state_d = ST_RUN;
                serve_d = '0;
              end else begin
                serve_d = serve_q + 4'd1;
              end
            end
          end
        end
        ST_RUN: begin
          if (miss) begin
            state_d = ST_SERVE;
            cnt_clr = 1'b1;
            serve_d = '0;
            hits_d  = '0;
            level_d = '0;
          end else begin
            if (pause_toggle) begin
              state_d = ST_PAUSE;
              saved_d = ST_RUN;
            end else begin
              cnt_en = 1'b1;
            end
            if (hit) begin
              if (hits_q == (HITS_PER_LEVEL - 4'd1)) begin
                hits_d = '0;
                if (level_q != MAX_LEVEL) begin
                  level_d = level_q + 3'd1;
                end
              end else begin
                hits_d = hits_q + 4'd1;
              end
            end
          end
        end
        ST_PAUSE: begin
          if (pause_toggle) begin
            state_d = saved_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state   = state_q;
  assign level   = level_q;
  assign running = (state_q == ST_RUN);

endmodule

// File: tb/tb_pong_tick_ctrl.sv
// Directed bench for pong_tick_ctrl using small divisors.
module tb_pong_tick_ctrl;

  logic       clock_in;
  logic       reset;
  logic       start;
  logic       stop;
  logic       pause_toggle;
  logic       hit;
  logic       miss;
  logic       ball_tick;
  logic       paddle_tick;
  logic [1:0] state;
  logic [2:0] level;
  logic       running;

  int errors;
  int checks;

  pong_tick_ctrl #(
    .CNT_W          (28),
    .BASE_DIV       (28'd10),
    .DIV_STEP       (28'd2),
    .MAX_LEVEL      (3'd3),
    .PADDLE_DIV     (28'd4),
    .SERVE_TICKS    (4'd2),
    .HITS_PER_LEVEL (4'd2)
  ) dut (
    .clock_in     (clock_in),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .pause_toggle (pause_toggle),
    .hit          (hit),
    .miss         (miss),
    .ball_tick    (ball_tick),
    .paddle_tick  (paddle_tick),
    .state        (state),
    .level        (level),
    .running      (running)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic step();
    @(posedge clock_in);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic pulse_hit();
    hit = 1'b1; step(); hit = 1'b0;
  endtask

  task automatic pulse_pause();
    pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
  endtask

  // Step until ball_tick is seen or the budget runs out; n = edges taken.
  task automatic wait_ball(input int max_cycles, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (ball_tick !== 1'b1 && n < max_cycles);
  endtask

  task automatic go_run();
    reset = 1'b1; step(); reset = 1'b0; step();
    pulse_start();
    repeat (20) step();
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL go_run_state: state=%0d expected 2", state); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %0b expected 0", running); end
    checks++; if (ball_tick !== 1'b0) begin errors++; $display("FAIL reset_ball_tick: got %0b expected 0", ball_tick); end
    checks++; if (paddle_tick !== 1'b0) begin errors++; $display("FAIL reset_paddle_tick: got %0b expected 0", paddle_tick); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_serve_to_run();
    logic exp;
    pulse_start();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d expected 1", state); end
    for (int i = 1; i <= 20; i++) begin
      step();
      exp = ((i % 4) == 0);
      checks++; if (paddle_tick !== exp) begin errors++; $display("FAIL serve_paddle_tick c%0d: got %0b expected %0b", i, paddle_tick, exp); end
      checks++; if (ball_tick !== 1'b0) begin errors++; $display("FAIL serve_ball_tick c%0d: got %0b expected 0", i, ball_tick); end
      if (i == 19) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL serve_hold c19: state=%0d expected 1", state); end
      end
    end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL serve_to_run c20: state=%0d expected 2", state); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL running_flag: got %0b expected 1", running); end
    for (int j = 1; j <= 30; j++) begin
      step();
      exp = ((j % 10) == 0);
      checks++; if (ball_tick !== exp) begin errors++; $display("FAIL run_ball_tick c%0d: got %0b expected %0b", j, ball_tick, exp); end
      exp = ((j % 4) == 0);
      checks++; if (paddle_tick !== exp) begin errors++; $display("FAIL run_paddle_tick c%0d: got %0b expected %0b", j, paddle_tick, exp); end
    end
  endtask

  task automatic test_speedup();
    int n;
    pulse_hit();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL one_hit_level: got %0d expected 0", level); end
    pulse_hit();
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL two_hit_level: got %0d expected 1", level); end
    wait_ball(20, n);
    checks++; if (ball_tick !== 1'b1) begin errors++; $display("FAIL lvl1_sync: ball_tick=%0b expected 1", ball_tick); end
    for (int k = 0; k < 2; k++) begin
      wait_ball(20, n);
      checks++; if (n !== 8) begin errors++; $display("FAIL lvl1_period: got %0d expected 8", n); end
    end
    hit = 1'b1;
    repeat (4) step();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL six_hit_level: got %0d expected 3", level); end
    repeat (2) step();
    hit = 1'b0;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL level_saturate: got %0d expected 3", level); end
    wait_ball(20, n);
    checks++; if (ball_tick !== 1'b1) begin errors++; $display("FAIL lvl3_sync: ball_tick=%0b expected 1", ball_tick); end
    for (int k = 0; k < 2; k++) begin
      wait_ball(20, n);
      checks++; if (n !== 4) begin errors++; $display("FAIL lvl3_period: got %0d expected 4", n); end
    end
  endtask

  task automatic test_miss();
    logic exp;
    go_run();
    repeat (4) pulse_hit();
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL pre_miss_level: got %0d expected 2", level); end
    miss = 1'b1; step(); miss = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL miss_state: got %0d expected 1", state); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL miss_level: got %0d expected 0", level); end
    for (int j = 1; j <= 40; j++) begin
      step();
      exp = (j == 30) || (j == 40);
      checks++; if (ball_tick !== exp) begin errors++; $display("FAIL reserve_ball_tick c%0d: got %0b expected %0b", j, ball_tick, exp); end
      if (j == 20) begin
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL reserve_run c20: state=%0d expected 2", state); end
      end
    end
  endtask

  task automatic test_pause();
    int ticks;
    logic exp;
    repeat (6) step();
    pulse_pause();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL pause_enter: state=%0d expected 3", state); end
    ticks = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (ball_tick === 1'b1 || paddle_tick === 1'b1) ticks++;
    end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL pause_ticks: got %0d expected 0", ticks); end
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL pause_hold: state=%0d expected 3", state); end
    pulse_pause();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_resume: state=%0d expected 2", state); end
    for (int k = 1; k <= 4; k++) begin
      step();
      exp = (k == 4);
      checks++; if (ball_tick !== exp) begin errors++; $display("FAIL resume_ball_tick c%0d: got %0b expected %0b", k, ball_tick, exp); end
    end
  endtask

  task automatic test_hit_miss_same();
    repeat (2) pulse_hit();
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL hm_pre_level: got %0d expected 1", level); end
    pulse_hit();
    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL hm_state: got %0d expected 1", state); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL hm_level: got %0d expected 0", level); end
    repeat (20) step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL hm_rerun: state=%0d expected 2", state); end
    pulse_hit();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL hm_hitcnt_cleared: level=%0d expected 0", level); end
    pulse_hit();
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL hm_hit_resume: level=%0d expected 1", level); end
  endtask

  task automatic test_stop_in_pause();
    int ticks;
    logic exp;
    pulse_pause();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL stop_pre_pause: state=%0d expected 3", state); end
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL stop_state: got %0d expected 0", state); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL stop_level: got %0d expected 0", level); end
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ball_tick === 1'b1 || paddle_tick === 1'b1) ticks++;
    end
    checks++; if (ticks !== 0) begin errors++; $display("FAIL idle_ticks: got %0d expected 0", ticks); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_hold: state=%0d expected 0", state); end
    pulse_start();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL restart_state: got %0d expected 1", state); end
    for (int i = 1; i <= 4; i++) begin
      step();
      exp = (i == 4);
      checks++; if (paddle_tick !== exp) begin errors++; $display("FAIL restart_paddle c%0d: got %0b expected %0b", i, paddle_tick, exp); end
    end
  endtask

  task automatic test_async_reset();
    go_run();
    repeat (2) pulse_hit();
    repeat (2) step();
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL ar_pre_level: got %0d expected 1", level); end
    checks++; if (paddle_tick !== 1'b1) begin errors++; $display("FAIL ar_pre_paddle: got %0b expected 1", paddle_tick); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL ar_pre_running: got %0b expected 1", running); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL ar_state: got %0d expected 0", state); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL ar_level: got %0d expected 0", level); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL ar_running: got %0b expected 0", running); end
    checks++; if (paddle_tick !== 1'b0) begin errors++; $display("FAIL ar_paddle: got %0b expected 0", paddle_tick); end
    checks++; if (ball_tick !== 1'b0) begin errors++; $display("FAIL ar_ball: got %0b expected 0", ball_tick); end
    step();
    reset = 1'b0;
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    reset        = 1'b1;
    start        = 1'b0;
    stop         = 1'b0;
    pause_toggle = 1'b0;
    hit          = 1'b0;
    miss         = 1'b0;
    test_reset();
    test_serve_to_run();
    test_speedup();
    test_miss();
    test_pause();
    test_hit_miss_same();
    test_stop_in_pause();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
